// File: rtl/router_pkg.sv
// Shared constants and lock-FSM encoding for the router FIFO read side.
package router_pkg;

  localparam int NUM_PORTS        = 5;
  localparam int PORT_N           = 0;
  localparam int PORT_E           = 1;
  localparam int PORT_S           = 2;
  localparam int PORT_W           = 3;
  localparam int PORT_L           = 4;
  localparam int DEFAULT_DATASIZE = 30;
  localparam int TAIL_BIT         = DEFAULT_DATASIZE - 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

endpackage

// File: rtl/rr_arbiter5.sv
// Five-way round-robin arbiter: searches upward from last_grant+1, wrapping,
// over requests qualified by enable and an optional lock mask.
module rr_arbiter5
  import router_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [2:0]           last_grant_i,
  input  logic                 en_i,
  input  logic [NUM_PORTS-1:0] mask_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [2:0]           gnt_idx_o,
  output logic                 gnt_vld_o
);

  logic [NUM_PORTS-1:0] req_m;
  logic [2:0]           idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    idx       = last_grant_i;
    req_m     = req_i & mask_i & {NUM_PORTS{en_i}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (idx == 3'(NUM_PORTS - 1)) ? 3'd0 : idx + 3'd1;
      if (!gnt_vld_o && req_m[idx]) begin
        gnt_vld_o  = 1'b1;
        gnt_idx_o  = idx;
        gnt_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_reader.sv
// Round-robin reader for the five input FIFOs, registering one flit per cycle
// downstream. Define FIFO_RR_READER_PKT_LOCK_EN to hold the grant for a whole packet.
module fifo_rr_reader
  import router_pkg::*;
#(
  parameter int DATASIZE = DEFAULT_DATASIZE
) (
  input  logic                fifo_clk,
  input  logic                rst_n,
  input  logic [DATASIZE-1:0] N_data_in,
  input  logic [DATASIZE-1:0] E_data_in,
  input  logic [DATASIZE-1:0] S_data_in,
  input  logic [DATASIZE-1:0] W_data_in,
  input  logic [DATASIZE-1:0] L_data_in,
  input  logic                N_valid_in,
  input  logic                E_valid_in,
  input  logic                S_valid_in,
  input  logic                W_valid_in,
  input  logic                L_valid_in,
  output logic                fifo_ready_N,
  output logic                fifo_ready_E,
  output logic                fifo_ready_S,
  output logic                fifo_ready_W,
  output logic                fifo_ready_L,
  output logic [DATASIZE-1:0] data_out,
  output logic                valid_out,
  input  logic                full_in
);

  logic [DATASIZE-1:0]  data_q, data_d;
  logic                 valid_q, valid_d;
  logic [2:0]           last_q, last_d;
  logic [DATASIZE-1:0]  din [NUM_PORTS];
  logic [NUM_PORTS-1:0] req, gnt, mask;
  logic [2:0]           gnt_idx;
  logic                 gnt_vld, can_load;

  assign din[PORT_N] = N_data_in;
  assign din[PORT_E] = E_data_in;
  assign din[PORT_S] = S_data_in;
  assign din[PORT_W] = W_data_in;
  assign din[PORT_L] = L_data_in;
  assign req         = {L_valid_in, W_valid_in, S_valid_in, E_valid_in, N_valid_in};
  assign can_load    = !valid_q || !full_in;

  // Gating with rst_n drops the pop strobes the instant reset asserts.
  rr_arbiter5 u_arb (
    .req_i        (req),
    .last_grant_i (last_q),
    .en_i         (can_load && rst_n),
    .mask_i       (mask),
    .gnt_o        (gnt),
    .gnt_idx_o    (gnt_idx),
    .gnt_vld_o    (gnt_vld)
  );

  assign {fifo_ready_L, fifo_ready_W, fifo_ready_S, fifo_ready_E, fifo_ready_N} = gnt;
  assign data_out  = data_q;
  assign valid_out = valid_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (can_load) begin
      valid_d = gnt_vld;
      if (gnt_vld) begin
        data_d = din[gnt_idx];
        last_d = gnt_idx;
      end
    end
  end

`ifdef FIFO_RR_READER_PKT_LOCK_EN
  localparam int TAIL = DATASIZE - 1;

  lock_state_e state_q, state_d;
  logic [2:0]  lock_port_q, lock_port_d;

  // While LOCKED only the locked port is eligible, even when its FIFO is empty.
  assign mask = (state_q == LOCKED) ? (NUM_PORTS'(1) << lock_port_q) : '1;

  always_comb begin
    state_d     = state_q;
    lock_port_d = lock_port_q;
    if (can_load && gnt_vld) begin
      case (state_q)
        IDLE: begin
          if (!din[gnt_idx][TAIL]) begin
            state_d     = LOCKED;
            lock_port_d = gnt_idx;
          end
        end
        LOCKED: begin
          if (din[gnt_idx][TAIL]) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge fifo_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lock_port_q <= '0;
    end else begin
      state_q     <= state_d;
      lock_port_q <= lock_port_d;
    end
  end
`else
  assign mask = '1;
`endif

  always_ff @(posedge fifo_clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 3'(PORT_L);
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

endmodule
